// File: rtl/latch_serializer_8bit.sv
// Serializer for the TI-side data latch. It loads a parallel byte on a
// Pi load strobe and shifts it out MSB-first, one bit per Pi shift strobe.
// Both strobes are asynchronous to clk, so each one is synchronized and
// edge-detected internally.
module latch_serializer_8bit #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:WIDTH-1] din,
    input  logic             le_in,
    input  logic             sclk_in,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic   [0:WIDTH-1]     r_shift;
    logic   [0:WIDTH-1]     w_shift_next;
    logic   [CW-1:0]        r_count;
    logic   [CW-1:0]        w_count_next;
    logic                   r_err;
    logic                   w_err_next;

    logic [SYNC_STAGES-1:0] r_le_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic                   r_le_hist;
    logic                   r_sclk_hist;
    logic                   w_le_pulse;
    logic                   w_sclk_pulse;

    // Strobe synchronizers plus one history flop each for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_le_sync   <= '0;
            r_sclk_sync <= '0;
            r_le_hist   <= 1'b0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_le_sync   <= {r_le_sync[SYNC_STAGES-2:0], le_in};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_le_hist   <= r_le_sync[SYNC_STAGES-1];
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_le_pulse   = r_le_sync[SYNC_STAGES-1] & ~r_le_hist;
    assign w_sclk_pulse = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_hist;

    // State, shift register, bit count and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_count <= w_count_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic; a load pulse always wins over a coincident shift pulse
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        w_err_next   = r_err;
        if (w_le_pulse) begin
            w_shift_next = din;
            w_count_next = '0;
            w_err_next   = 1'b0;
            w_state_next = StShift;
        end else if (w_sclk_pulse) begin
            unique case (r_state)
                StIdle: begin
                    w_err_next = 1'b1;
                end
                StShift: begin
                    w_shift_next = {r_shift[1:WIDTH-1], 1'b0};
                    if (r_count == CW'(WIDTH - 1)) begin
                        w_count_next = CW'(WIDTH);
                        w_state_next = StDone;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
                StDone: begin
                    // Count is already saturated at WIDTH; only zeros move in
                    w_shift_next = {r_shift[1:WIDTH-1], 1'b0};
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    assign sout = r_shift[0];
    assign busy = (r_state == StShift);
    assign done = (r_state == StDone);
    assign err  = r_err;

endmodule

// File: tb/tb_latch_serializer_8bit.sv
// Self-checking bench for latch_serializer_8bit: a directed vector table,
// hand-written reset sequences and randomized strobes against a byte-level model.
module tb_latch_serializer_8bit;

    localparam int OpLoad  = 0;
    localparam int OpShift = 1;
    localparam int OpBoth  = 2;

    typedef struct {
        int         op;
        logic [7:0] din;
        logic       sout;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [0:7] din;
    logic       le_in;
    logic       sclk_in;
    logic       sout;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the loaded byte and how many bits have left it
    logic [0:7] m_byte;
    int         m_k;
    bit         m_loaded;
    bit         m_err;

    vec_t vecs[$];

    latch_serializer_8bit #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (din),
        .le_in  (le_in),
        .sclk_in(sclk_in),
        .sout   (sout),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic logic exp_sout();
        if (m_loaded && m_k < 8) return m_byte[m_k];
        return 1'b0;
    endfunction

    task automatic check_model(input string name);
        check({name, ".sout"}, sout, exp_sout());
        check({name, ".busy"}, busy, m_loaded && m_k < 8);
        check({name, ".done"}, done, m_loaded && m_k >= 8);
        check({name, ".err"}, err, m_err);
    endtask

    task automatic model_reset();
        m_byte   = '0;
        m_k      = 0;
        m_loaded = 0;
        m_err    = 0;
    endtask

    task automatic model_apply(input int op, input logic [7:0] d);
        if (op == OpLoad || op == OpBoth) begin
            m_byte   = d;
            m_k      = 0;
            m_loaded = 1;
            m_err    = 0;
        end else if (!m_loaded) begin
            m_err = 1;
        end else if (m_k < 8) begin
            m_k++;
        end
    endtask

    // Strobes are held high and low 4 clks each, longer than the 3-edge latency
    task automatic strobe(input int op, input logic [7:0] d);
        @(negedge clk);
        din = d;
        if (op != OpShift) le_in = 1'b1;
        if (op != OpLoad) sclk_in = 1'b1;
        repeat (4) @(negedge clk);
        le_in   = 1'b0;
        sclk_in = 1'b0;
        repeat (4) @(negedge clk);
        model_apply(op, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    function automatic vec_t mk(input int op, input logic [7:0] d, input logic s,
                                input logic b, input logic dn, input logic e);
        vec_t v;
        v.op   = op;
        v.din  = d;
        v.sout = s;
        v.busy = b;
        v.done = dn;
        v.err  = e;
        return v;
    endfunction

    initial begin
        reset_n = 1'b0;
        din     = '0;
        le_in   = 1'b0;
        sclk_in = 1'b0;
        model_reset();

        // Reset held while strobes toggle: outputs must stay cleared
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            le_in   = i[1];
            sclk_in = i[0];
            din     = 8'hFF;
            check($sformatf("rst_hold%0d.sout", i), sout, 1'b0);
            check($sformatf("rst_hold%0d.busy", i), busy, 1'b0);
            check($sformatf("rst_hold%0d.done", i), done, 1'b0);
            check($sformatf("rst_hold%0d.err", i), err, 1'b0);
        end
        le_in   = 1'b0;
        sclk_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_model("rst_release");

        // Directed table, hand-derived expectations
        vecs.push_back(mk(OpShift, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(OpLoad,  8'h5A, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 1, 1, 0, 0));
        vecs.push_back(mk(OpLoad,  8'hAA, 1, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'hFF, 1, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'hFF, 1, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'hFF, 1, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(OpLoad,  8'hC3, 1, 1, 0, 0));
        vecs.push_back(mk(OpBoth,  8'h81, 1, 1, 0, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(OpShift, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 1, 1, 0, 0));
        vecs.push_back(mk(OpShift, 8'h00, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            strobe(vecs[i].op, vecs[i].din);
            check($sformatf("vec%0d.sout", i), sout, vecs[i].sout);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d.done", i), done, vecs[i].done);
            check($sformatf("vec%0d.err", i), err, vecs[i].err);
        end

        // Asynchronous reset mid-transfer, asserted between clk edges
        do_reset();
        strobe(OpLoad, 8'hFF);
        for (int i = 0; i < 3; i++) strobe(OpShift, 8'h00);
        check_model("mid_xfer");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.sout", sout, 1'b0);
        check("async_rst.busy", busy, 1'b0);
        check("async_rst.done", done, 1'b0);
        check("async_rst.err", err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        strobe(OpShift, 8'h00);
        check("post_rst_shift.err", err, 1'b1);
        check_model("post_rst_shift");

        // Randomized strobes against the model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            int          r;
            int          op;
            logic [7:0]  d;
            r  = int'($urandom_range(0, 9));
            op = (r < 2) ? OpLoad : (r == 2) ? OpBoth : OpShift;
            d  = 8'($urandom);
            strobe(op, d);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
